// File: rtl/d_encoder_if.sv
// d_encoder_if: request handshake and instruction-memory write port of d_encoder
interface d_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_size64;
  logic [4:0]  in_rn;
  logic [4:0]  in_rt;
  logic [8:0]  in_offset;
  logic        im_write;
  logic [63:0] im_addr;
  logic [31:0] im_data;
  logic        im_busy;
  modport master (
    output in_valid, in_load, in_size64, in_rn, in_rt, in_offset, im_busy,
    input  in_ready, im_write, im_addr, im_data
  );
  modport slave (
    input  in_valid, in_load, in_size64, in_rn, in_rt, in_offset, im_busy,
    output in_ready, im_write, im_addr, im_data
  );
endinterface

// File: rtl/d_encoder.sv
// d_encoder: D-format LDUR/STUR word encoder with 2-entry FIFO feeding an instruction-memory write port.
// Define D_ENCODER_BYTE_SIZE_EN to honour in_size64 (8-bit opcodes); otherwise all words use 64-bit opcodes.
module d_encoder (
  input  logic         clock,
  input  logic         reset,
  d_encoder_if.slave   bus,
  input  logic [63:0]  base_addr,
  input  logic         base_load,
  output logic [15:0]  emitted
);
  typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;
  state_t      state;
  logic [31:0] mem [2];
  logic        wp, rp, rp_n, sz, push, pop;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] word, head_n;
`ifdef D_ENCODER_BYTE_SIZE_EN
  assign sz = bus.in_size64;
`else
  assign sz = 1'b1;
`endif
  assign pop          = state != IDLE && !bus.im_busy;
  assign bus.in_ready = cnt != 2'd2 || pop;
  assign push         = bus.in_valid && bus.in_ready;
  always_comb begin
    word   = {sz ? 2'b11 : 2'b00, 3'b111, 4'b0000, bus.in_load, 1'b0, bus.in_offset, 2'b00, bus.in_rn, bus.in_rt};
    cnt_n  = cnt + {1'b0, push} - {1'b0, pop};
    rp_n   = rp ^ pop;
    // an entry pushed into the slot that becomes head must bypass the storage
    head_n = (push && wp == rp_n) ? word : mem[rp_n];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      mem[0]       <= 32'd0;
      mem[1]       <= 32'd0;
      bus.im_write <= 1'b0;
      bus.im_addr  <= 64'd0;
      bus.im_data  <= 32'd0;
      emitted      <= 16'd0;
    end else if (base_load) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      bus.im_write <= 1'b0;
      bus.im_addr  <= base_addr;
    end else begin
      if (push) begin
        mem[wp] <= word;
        wp      <= ~wp;
      end
      if (pop) begin
        bus.im_addr <= bus.im_addr + 64'd4;
        emitted     <= emitted + 16'd1;
      end
      if (cnt_n != 2'd0) bus.im_data <= head_n;
      rp           <= rp_n;
      cnt          <= cnt_n;
      bus.im_write <= cnt_n != 2'd0;
      state        <= cnt_n == 2'd0 ? IDLE : (state != IDLE && bus.im_busy) ? HOLD : EMIT;
    end
  end
endmodule
